// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the accumulator-machine control unit.
// Field widths, opcode encodings, datapath control constants, the FSM state
// encoding and the decoded control word carried from bip_decoder to the top.
package bip_pkg;

    localparam int unsigned PC_BITS  = 11;
    localparam int unsigned OPC_BITS = 5;
    localparam int unsigned D_BITS   = 11;
    localparam int unsigned S_BITS   = 2;
    localparam int unsigned I_BITS   = OPC_BITS + D_BITS;

    // Opcodes (instr[15:11]); every other value executes as a NOP
    localparam logic [OPC_BITS-1:0] OPC_HLT  = OPC_BITS'(0);
    localparam logic [OPC_BITS-1:0] OPC_STO  = OPC_BITS'(1);
    localparam logic [OPC_BITS-1:0] OPC_LD   = OPC_BITS'(2);
    localparam logic [OPC_BITS-1:0] OPC_LDI  = OPC_BITS'(3);
    localparam logic [OPC_BITS-1:0] OPC_ADD  = OPC_BITS'(4);
    localparam logic [OPC_BITS-1:0] OPC_ADDI = OPC_BITS'(5);
    localparam logic [OPC_BITS-1:0] OPC_SUB  = OPC_BITS'(6);
    localparam logic [OPC_BITS-1:0] OPC_SUBI = OPC_BITS'(7);

    // Datapath mux / ALU controls
    localparam logic [S_BITS-1:0] SEL_A_RAM = S_BITS'(0);
    localparam logic [S_BITS-1:0] SEL_A_EXT = S_BITS'(1);
    localparam logic [S_BITS-1:0] SEL_A_ALU = S_BITS'(2);
    localparam logic              SEL_B_RAM = 1'b0;
    localparam logic              SEL_B_EXT = 1'b1;
    localparam logic              OP_ADD    = 1'b0;
    localparam logic              OP_SUB    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEMRD  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Decoded control word for one opcode
    typedef struct packed {
        logic [S_BITS-1:0] sel_a;
        logic              sel_b;
        logic              op;
        logic              w_acc;
        logic              wr_ram;
        logic              needs_mem;
        logic              is_halt;
    } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: combinational opcode -> control word decode.
// Ports:
//   opcode  in   OPC_BITS  opcode field
//   ctrl_c  out  ctrl_t    {sel_a, sel_b, op, w_acc, wr_ram, needs_mem, is_halt}
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_BITS-1:0] opcode,
    output ctrl_t               ctrl_c
);

    // Unlisted opcodes fall through to the all-zero NOP word
    always_comb begin
        ctrl_c = '0;
        case (opcode)
            OPC_HLT: ctrl_c.is_halt = 1'b1;
            OPC_STO: ctrl_c.wr_ram  = 1'b1;
            OPC_LD: begin
                ctrl_c.sel_a     = SEL_A_RAM;
                ctrl_c.w_acc     = 1'b1;
                ctrl_c.needs_mem = 1'b1;
            end
            OPC_LDI: begin
                ctrl_c.sel_a = SEL_A_EXT;
                ctrl_c.w_acc = 1'b1;
            end
            OPC_ADD: begin
                ctrl_c.sel_a     = SEL_A_ALU;
                ctrl_c.sel_b     = SEL_B_RAM;
                ctrl_c.op        = OP_ADD;
                ctrl_c.w_acc     = 1'b1;
                ctrl_c.needs_mem = 1'b1;
            end
            OPC_ADDI: begin
                ctrl_c.sel_a = SEL_A_ALU;
                ctrl_c.sel_b = SEL_B_EXT;
                ctrl_c.op    = OP_ADD;
                ctrl_c.w_acc = 1'b1;
            end
            OPC_SUB: begin
                ctrl_c.sel_a     = SEL_A_ALU;
                ctrl_c.sel_b     = SEL_B_RAM;
                ctrl_c.op        = OP_SUB;
                ctrl_c.w_acc     = 1'b1;
                ctrl_c.needs_mem = 1'b1;
            end
            OPC_SUBI: begin
                ctrl_c.sel_a = SEL_A_ALU;
                ctrl_c.sel_b = SEL_B_EXT;
                ctrl_c.op    = OP_SUB;
                ctrl_c.w_acc = 1'b1;
            end
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/bip_control_unit.sv
// bip_control_unit: fetch/decode/execute sequencer for the accumulator datapath.
// Owns the PC, IR and run/halt status; drives datapath and data-RAM controls.
// Optional build macro: BIP_SINGLE_STEP_EN adds i_step and returns to IDLE after
// every instruction, so one instruction runs per i_run/i_step pulse.
// Ports:
//   i_clock, i_reset           clock, async active-high reset
//   i_run                      start execution from IDLE
//   i_step                     step request (BIP_SINGLE_STEP_EN only)
//   i_instr   [15:0]           program-memory data, valid the cycle after o_pc
//   o_pc      [10:0]           program-memory address
//   o_operand [10:0]           IR operand field (immediate / RAM address)
//   o_sel_A, o_sel_B, o_op     accumulator mux, ALU operand mux, ALU op
//   o_w_acc                    accumulator write enable (EXEC only)
//   o_rd_ram, o_wr_ram         data-RAM strobes (MEMRD / EXEC)
//   o_busy, o_halt             running / halted status
module bip_control_unit
    import bip_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_run,
`ifdef BIP_SINGLE_STEP_EN
    input  logic                i_step,
`endif
    input  logic [I_BITS-1:0]   i_instr,
    output logic [PC_BITS-1:0]  o_pc,
    output logic [D_BITS-1:0]   o_operand,
    output logic [S_BITS-1:0]   o_sel_A,
    output logic                o_sel_B,
    output logic                o_op,
    output logic                o_w_acc,
    output logic                o_rd_ram,
    output logic                o_wr_ram,
    output logic                o_busy,
    output logic                o_halt
);

    state_t               state;
    logic [PC_BITS-1:0]   pc;
    logic [I_BITS-1:0]    ir;
    logic                 start_c;
    logic [OPC_BITS-1:0]  dec_opcode_c;
    ctrl_t                ctrl_c;

`ifdef BIP_SINGLE_STEP_EN
    assign start_c = i_run | i_step;
`else
    assign start_c = i_run;
`endif

    // In DECODE the word is still on i_instr (IR loads at the end of DECODE);
    // later states decode the IR. This lets the EXEC controls be registered.
    assign dec_opcode_c = (state == ST_DECODE) ? i_instr[I_BITS-1:D_BITS]
                                               : ir[I_BITS-1:D_BITS];

    bip_decoder u_decoder (
        .opcode (dec_opcode_c),
        .ctrl_c (ctrl_c)
    );

    assign o_pc      = pc;
    assign o_operand = ir[D_BITS-1:0];

    // Sequencer: strobes default low each cycle and are set on entry to the
    // state that owns them, so each one is a single-cycle pulse.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            o_sel_A  <= '0;
            o_sel_B  <= 1'b0;
            o_op     <= 1'b0;
            o_w_acc  <= 1'b0;
            o_rd_ram <= 1'b0;
            o_wr_ram <= 1'b0;
            o_busy   <= 1'b0;
            o_halt   <= 1'b0;
        end else begin
            o_sel_A  <= '0;
            o_sel_B  <= 1'b0;
            o_op     <= 1'b0;
            o_w_acc  <= 1'b0;
            o_rd_ram <= 1'b0;
            o_wr_ram <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_c) begin
                        state  <= ST_FETCH;
                        o_busy <= 1'b1;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    ir <= i_instr;
                    if (ctrl_c.is_halt) begin
                        state  <= ST_HALT;
                        o_busy <= 1'b0;
                        o_halt <= 1'b1;
                    end else if (ctrl_c.needs_mem) begin
                        state    <= ST_MEMRD;
                        o_rd_ram <= 1'b1;
                    end else begin
                        state    <= ST_EXEC;
                        o_sel_A  <= ctrl_c.sel_a;
                        o_sel_B  <= ctrl_c.sel_b;
                        o_op     <= ctrl_c.op;
                        o_w_acc  <= ctrl_c.w_acc;
                        o_wr_ram <= ctrl_c.wr_ram;
                    end
                end
                ST_MEMRD: begin
                    state    <= ST_EXEC;
                    o_sel_A  <= ctrl_c.sel_a;
                    o_sel_B  <= ctrl_c.sel_b;
                    o_op     <= ctrl_c.op;
                    o_w_acc  <= ctrl_c.w_acc;
                    o_wr_ram <= ctrl_c.wr_ram;
                end
                ST_EXEC: begin
                    pc <= pc + PC_BITS'(1);
`ifdef BIP_SINGLE_STEP_EN
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
`else
                    state  <= ST_FETCH;
`endif
                end
                ST_HALT: state <= ST_HALT;
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    o_halt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: randomized, scoreboard-checked bench for bip_control_unit.
// An instruction-level interpreter predicts every strobe (with its cycle) and the
// final accumulator/RAM; a monitor drives a behavioural datapath from the DUT
// strobes and pops/compares predicted strobes as they appear.
`timescale 1ns/1ps
module tb_bip_control_unit;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        wacc;
        logic [1:0]  sel_a;
        logic        sel_b;
        logic        op;
        logic [10:0] operand;
        logic [10:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_run = 1'b0;
`ifdef BIP_SINGLE_STEP_EN
    logic        i_step = 1'b0;
`endif
    logic [15:0] i_instr = '0;
    logic [10:0] o_pc, o_operand;
    logic [1:0]  o_sel_A;
    logic        o_sel_B, o_op, o_w_acc, o_rd_ram, o_wr_ram, o_busy, o_halt;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          load_seq = 0;
    int          wacc_seen = 0;

    logic [15:0] prog     [0:2047];
    logic [15:0] ram_init [0:2047];
    logic [15:0] ram      [0:2047];
    logic [15:0] m_ram    [0:2047];
    logic [15:0] acc = '0, ram_q = '0, m_acc = '0;
    ev_t         exp_q[$];
    int          exp_cyc_q[$];

    bip_control_unit dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_run     (i_run),
`ifdef BIP_SINGLE_STEP_EN
        .i_step    (i_step),
`endif
        .i_instr   (i_instr),
        .o_pc      (o_pc),
        .o_operand (o_operand),
        .o_sel_A   (o_sel_A),
        .o_sel_B   (o_sel_B),
        .o_op      (o_op),
        .o_w_acc   (o_w_acc),
        .o_rd_ram  (o_rd_ram),
        .o_wr_ram  (o_wr_ram),
        .o_busy    (o_busy),
        .o_halt    (o_halt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Synchronous program memory
    always @(posedge clk) i_instr <= prog[o_pc];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [30:0] outs();
        return {o_pc, o_operand, o_sel_A, o_sel_B, o_op, o_w_acc, o_rd_ram, o_wr_ram, o_busy, o_halt};
    endfunction

    function automatic ev_t mk_ev(logic rd, logic wr, logic wacc, logic [1:0] sa, logic sb,
                                  logic op, logic [10:0] opd, logic [10:0] pc);
        return {rd, wr, wacc, sa, sb, op, opd, pc};
    endfunction

    task automatic push(input int c, input ev_t e);
        exp_q.push_back(e);
        exp_cyc_q.push_back(c);
    endtask

    // Monitor + behavioural datapath (sole owner of ram/acc)
    initial begin : monitor
        int   load_done;
        int   ec;
        ev_t  got, expv;
        logic [15:0] b;
        load_done = 0;
        forever begin
            @(negedge clk);
            if (load_seq != load_done) begin
                load_done = load_seq;
                for (int i = 0; i < 2048; i++) ram[i] = ram_init[i];
                acc = '0;
                ram_q = '0;
            end
            if (!i_reset && (o_rd_ram || o_wr_ram || o_w_acc)) begin
                got = {o_rd_ram, o_wr_ram, o_w_acc, o_sel_A, o_sel_B, o_op, o_operand, o_pc};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got 0x%0h at cycle %0d, required no strobe", got, cyc);
                end else begin
                    expv = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("strobe_word", 64'(got), 64'(expv));
`ifndef BIP_SINGLE_STEP_EN
                    check("strobe_cycle", 64'(cyc), 64'(ec));
`endif
                end
                if (o_w_acc) wacc_seen++;
                b = o_sel_B ? 16'(o_operand) : ram_q;
                if (o_wr_ram) ram[o_operand] = acc;
                if (o_w_acc) begin
                    case (o_sel_A)
                        2'b00:   acc = ram_q;
                        2'b01:   acc = 16'(o_operand);
                        2'b10:   acc = o_op ? acc - b : acc + b;
                        default: acc = acc;
                    endcase
                end
                if (o_rd_ram) ram_q = ram[o_operand];
            end
        end
    end

    // Instruction-level reference: fetch at cycle f, EXEC at f+2 (f+3 with a
    // RAM read at f+2), next fetch after EXEC; HLT shows o_halt at f+2.
    task automatic model_run(input int f0, input bit patch_wrap, input int max_instr,
                             output int halt_cyc, output logic [10:0] halt_pc);
        logic [15:0] mprog [0:2047];
        logic [15:0] instr;
        logic [4:0]  opc;
        logic [10:0] opd;
        logic [10:0] pc;
        int          f;
        f = f0;
        pc = '0;
        halt_cyc = 0;
        halt_pc = '0;
        for (int i = 0; i < 2048; i++) begin
            mprog[i] = prog[i];
            m_ram[i] = ram_init[i];
        end
        m_acc = '0;
        for (int n = 0; n < max_instr; n++) begin
            instr = mprog[pc];
            opc = instr[15:11];
            opd = instr[10:0];
            if (opc == 5'd0) begin
                halt_cyc = f + 2;
                halt_pc = pc;
                break;
            end
            case (opc)
                5'd1: begin push(f + 2, mk_ev(0, 1, 0, 2'b00, 0, 0, opd, pc)); m_ram[opd] = m_acc; f += 3; end
                5'd2: begin push(f + 2, mk_ev(1, 0, 0, 2'b00, 0, 0, opd, pc));
                            push(f + 3, mk_ev(0, 0, 1, 2'b00, 0, 0, opd, pc)); m_acc = m_ram[opd]; f += 4; end
                5'd3: begin push(f + 2, mk_ev(0, 0, 1, 2'b01, 0, 0, opd, pc)); m_acc = 16'(opd); f += 3; end
                5'd4: begin push(f + 2, mk_ev(1, 0, 0, 2'b00, 0, 0, opd, pc));
                            push(f + 3, mk_ev(0, 0, 1, 2'b10, 0, 0, opd, pc)); m_acc = m_acc + m_ram[opd]; f += 4; end
                5'd5: begin push(f + 2, mk_ev(0, 0, 1, 2'b10, 1, 0, opd, pc)); m_acc = m_acc + 16'(opd); f += 3; end
                5'd6: begin push(f + 2, mk_ev(1, 0, 0, 2'b00, 0, 0, opd, pc));
                            push(f + 3, mk_ev(0, 0, 1, 2'b10, 0, 1, opd, pc)); m_acc = m_acc - m_ram[opd]; f += 4; end
                5'd7: begin push(f + 2, mk_ev(0, 0, 1, 2'b10, 1, 1, opd, pc)); m_acc = m_acc - 16'(opd); f += 3; end
                default: f += 3;
            endcase
            if (patch_wrap && pc == 11'h7FF) mprog[0] = 16'h0000;
            pc = pc + 11'd1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) begin
            prog[i] = 16'h0000;
            ram_init[i] = 16'h0000;
        end
    endtask

    task automatic load_ram();
        load_seq++;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Drives i_run on each negedge; in step builds re-launches whenever idle
    task automatic run_tick(input bit hold_run);
`ifdef BIP_SINGLE_STEP_EN
        i_run = (hold_run || (!o_busy && !o_halt)) ? 1'b1 : 1'b0;
`else
        i_run = hold_run;
`endif
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        i_run = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);
        check({name, "_held"}, 64'(outs()), 64'd0);
        i_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_idle"}, 64'(outs()), 64'd0);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic run_prog(input string name, input bit patch_wrap, input bit hold_run, input int budget);
        int          f0, hc, hcyc, mism;
        logic [10:0] hp;
        bit          seen;
        @(negedge clk);
        f0 = cyc + 1;
        model_run(f0, patch_wrap, 4096, hc, hp);
        i_run = 1'b1;
        seen = 0;
        hcyc = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            run_tick(hold_run);
            if (patch_wrap && o_pc == 11'h7FF) prog[0] = 16'h0000;
            if (o_halt) begin
                seen = 1;
                hcyc = cyc;
            end
        end
        i_run = 1'b0;
        check({name, "_halt_reached"}, 64'(seen), 64'd1);
        if (seen) begin
`ifndef BIP_SINGLE_STEP_EN
            check({name, "_halt_cycle"}, 64'(hcyc), 64'(hc));
`endif
            check({name, "_halt_pc"}, 64'(o_pc), 64'(hp));
            check({name, "_halt_not_busy"}, 64'(o_busy), 64'd0);
        end
        // i_run after halt must not restart anything
        i_run = 1'b1;
        repeat (3) @(negedge clk);
        i_run = 1'b0;
        check({name, "_halt_sticky"}, 64'({o_halt, o_pc}), 64'({1'b1, hp}));
        check({name, "_acc"}, 64'(acc), 64'(m_acc));
        mism = 0;
        for (int i = 0; i < 2048; i++) if (ram[i] !== m_ram[i]) mism++;
        check({name, "_ram_mismatches"}, 64'(mism), 64'd0);
        check({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic gen_random();
        logic [4:0]  opc;
        logic [10:0] opd;
        clear_mem();
        for (int i = 0; i < 24; i++) begin
            opc = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 3) != 0) opc = 5'($urandom_range(1, 7));
            if (opc == 5'd1 || opc == 5'd2 || opc == 5'd4 || opc == 5'd6)
                opd = 11'($urandom_range(0, 15));
            else
                opd = 11'($urandom);
            prog[i] = {opc, opd};
        end
        for (int i = 0; i < 16; i++) ram_init[i] = 16'($urandom);
    endtask

    initial begin : stim
        int          hc, f0;
        logic [10:0] hp;
        bit          found;
        clear_mem();
        load_ram();
        do_reset("reset_initial");

        // LDI 5; ADDI 3; STO 0x010; HLT
        clear_mem();
        prog[0] = {5'd3, 11'd5};
        prog[1] = {5'd5, 11'd3};
        prog[2] = {5'd1, 11'h010};
        prog[3] = 16'h0000;
        load_ram();
        run_prog("prog_sto", 0, 0, 100);
        check("prog_sto_acc8", 64'(acc), 64'd8);
        check("prog_sto_ram10", 64'(ram[16]), 64'd8);
        check("prog_sto_pc3", 64'(o_pc), 64'd3);

        // LD 4; LDI 1; SUB 2; HLT with RAM[4]=0x1234, RAM[2]=3
        do_reset("reset_ld");
        clear_mem();
        ram_init[4] = 16'h1234;
        ram_init[2] = 16'd3;
        prog[0] = {5'd2, 11'd4};
        prog[1] = {5'd3, 11'd1};
        prog[2] = {5'd6, 11'd2};
        prog[3] = 16'h0000;
        load_ram();
        run_prog("prog_ld_sub", 0, 0, 100);
        check("prog_ld_sub_acc", 64'(acc), 64'hFFFE);

        for (int r = 0; r < 4; r++) begin
            do_reset("reset_rand");
            gen_random();
            load_ram();
            run_prog($sformatf("rand%0d", r), 0, r[0], 400);
        end

        // 2047 NOPs then opcode 11111 at 0x7FF; PC wraps to a HLT at 0
        do_reset("reset_wrap");
        clear_mem();
        for (int i = 0; i < 2047; i++) prog[i] = {5'($urandom_range(8, 31)), 11'($urandom)};
        prog[2047] = {5'b11111, 11'($urandom)};
        load_ram();
        run_prog("pc_wrap", 1, 0, 8000);
        check("pc_wrap_pc0", 64'(o_pc), 64'd0);

        // Async reset in the EXEC cycle of ADDI
        do_reset("reset_pre_abort");
        clear_mem();
        prog[0] = {5'd3, 11'd5};
        prog[1] = {5'd5, 11'd3};
        load_ram();
        @(negedge clk);
        f0 = cyc + 1;
        model_run(f0, 0, 2, hc, hp);
        i_run = 1'b1;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            run_tick(0);
            if (o_w_acc && o_sel_A == 2'b10) found = 1;
        end
        check("abort_addi_exec_seen", 64'(found), 64'd1);
        #2;
        i_reset = 1'b1;
        i_run = 1'b0;
        #1;
        check("abort_async_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        i_reset = 1'b0;
        check("abort_events_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 64'(outs()), 64'd0);

`ifdef BIP_SINGLE_STEP_EN
        // One i_step pulse executes exactly one instruction
        do_reset("reset_step");
        clear_mem();
        prog[0] = {5'd3, 11'd1};
        prog[1] = {5'd3, 11'd2};
        load_ram();
        wacc_seen = 0;
        @(negedge clk);
        f0 = cyc + 1;
        model_run(f0, 0, 1, hc, hp);
        i_step = 1'b1;
        @(negedge clk);
        i_step = 1'b0;
        repeat (8) @(negedge clk);
        check("step_wacc_pulses", 64'(wacc_seen), 64'd1);
        check("step_idle_pc1", 64'({o_busy, o_halt, o_pc}), 64'({1'b0, 1'b0, 11'd1}));
        check("step_acc", 64'(acc), 64'd1);
        check("step_events_left", 64'(exp_q.size()), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
